// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default frame/FIFO sizes
package uart_pkg;
  typedef enum logic [1:0] {WAITHIGH, IDLE, DATA, STOP} uart_state_e;
  localparam int UART_BITS = 8;
  localparam int UART_RX_DEPTH = 4;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO, head reads 0 when empty, push refused when full unless popping
module uart_rx_fifo import uart_pkg::*; #(
  parameter int width = UART_BITS,
  parameter int depth = UART_RX_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem_q [depth];
  logic [aw-1:0] wr_q, rd_q;
  logic [aw:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (aw+1)'(depth);
  assign empty = cnt_q == '0;
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (aw+1)'(do_push) - (aw+1)'(do_pop);
    end
endmodule

// File: rtl/uart_receive.sv
// uart_receive: one-bit-per-clock 8N1 receiver feeding a valid/ready FIFO.
// UART_RX_SYNC_EN adds a two-flop input synchronizer for asynchronous lines.
module uart_receive import uart_pkg::*; #(
  parameter int bits = UART_BITS,
  parameter int depth = UART_RX_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in,
  output logic [bits-1:0] out,
  output logic            valid,
  input  logic            ready,
  output logic            busy,
  output logic            frameErr,
  output logic            overrun
);
  localparam int iw = $clog2(bits);
  uart_state_e state_q;
  logic [iw-1:0] idx_q;
  logic [bits-1:0] shift_q;
  logic busy_q, fe_q, ov_q;
  logic s, push, pop, full, empty;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk)
    if (rst) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], in};
  assign s = sync_q[1];
`else
  assign s = in;
`endif
  assign push = state_q == STOP & s;
  assign valid = !empty;
  assign pop = valid & ready;
  assign busy = busy_q;
  assign frameErr = fe_q;
  assign overrun = ov_q;
  uart_rx_fifo #(.width(bits), .depth(depth)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(shift_q),
    .dout(out), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= WAITHIGH;
      idx_q <= '0;
      shift_q <= '0;
      busy_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      ov_q <= push & full & !pop;
      case (state_q)
        WAITHIGH: if (s) state_q <= IDLE;
        IDLE: if (en & !s) begin
          state_q <= DATA;
          idx_q <= '0;
          busy_q <= 1'b1;
        end
        DATA: begin
          shift_q <= {s, shift_q[bits-1:1]};
          if (idx_q == iw'(bits-1)) state_q <= STOP;
          else idx_q <= idx_q + 1'b1;
        end
        STOP: begin
          busy_q <= 1'b0;
          fe_q <= !s;
          state_q <= s ? IDLE : WAITHIGH;
        end
        default: state_q <= WAITHIGH;
      endcase
    end
endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: scoreboard bench driving serial frames into uart_receive
module tb_uart_receive;
  logic clk = 0, rst = 1, en = 1, ser = 1, ready = 1;
  logic [7:0] dout;
  logic valid, busy, frameErr, overrun;
  int checks = 0, errors = 0;
  int fe_cnt = 0, ov_cnt = 0, busy_cyc = 0;
  logic [7:0] exp_q [$];

  uart_receive #(.bits(8), .depth(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in(ser), .out(dout), .valid(valid),
    .ready(ready), .busy(busy), .frameErr(frameErr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frameErr) fe_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_cyc++;
      if (!valid) chk("out_idle_zero", dout, 0);
      if (valid && ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", dout, 32'hdead);
        else chk("data", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    int fe0, ov0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", dout, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", frameErr, 0);
    chk("rst_ov", overrun, 0);
    rst = 0;
    send_bit(1);
    send_bit(1);
    // single byte, latency and busy width
    busy_cyc = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1);
    chk("lat_valid", valid, 1);
    send_bit(1);
    send_bit(1);
    chk("busy_cycles", busy_cyc, 9);
    chk("a5_drained", exp_q.size(), 0);
    chk("a5_fe", fe_cnt, 0);
    chk("a5_ov", ov_cnt, 0);
    // back-to-back frames held in FIFO
    ready = 0;
    foreach (exp_q[i]) ;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF);
    send_frame(8'h01, 1);
    send_frame(8'h80, 1);
    send_frame(8'hFF, 1);
    send_bit(1);
    chk("b2b_valid", valid, 1);
    chk("b2b_head", dout, 8'h01);
    ready = 1;
    repeat (5) send_bit(1);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_empty", valid, 0);
    // overrun on fifth frame
    ready = 0;
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1);
    end
    send_bit(1);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    ready = 1;
    repeat (6) send_bit(1);
    chk("ovr_drained", exp_q.size(), 0);
    // framing error and recovery
    fe0 = fe_cnt;
    send_frame(8'h3C, 0);
    send_bit(0);
    busy_cyc = 0;
    send_bit(0);
    send_bit(0);
    send_bit(0);
    chk("fe_pulses", fe_cnt - fe0, 1);
    chk("fe_no_push", valid, 0);
    chk("fe_no_busy", busy_cyc, 0);
    send_bit(1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1);
    send_bit(1);
    send_bit(1);
    chk("fe_recover", exp_q.size(), 0);
    // reset mid-frame with line low
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_bit(0);
    repeat (4) send_bit(0);
    ser = 0;
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_out", dout, 0);
    @(posedge clk);
    #1;
    rst = 0;
    send_bit(0);
    send_bit(0);
    send_bit(1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1);
    send_bit(1);
    send_bit(1);
    chk("rst_recover", exp_q.size(), 0);
    chk("rst_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    // enable gating
    en = 0;
    busy_cyc = 0;
    send_frame(8'h77, 1);
    send_bit(1);
    chk("en_off_busy", busy_cyc, 0);
    chk("en_off_valid", valid, 0);
    en = 1;
    exp_q.push_back(8'h96);
    send_bit(0);
    en = 0;
    for (int i = 0; i < 8; i++) send_bit(8'h96 >> i & 1);
    send_bit(1);
    send_bit(1);
    send_bit(1);
    en = 1;
    chk("en_drop_done", exp_q.size(), 0);
    chk("final_fe", fe_cnt, 1);
    chk("final_ov", ov_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_receive.md
# uart_receive

Serial-to-parallel UART receiver, the receive-side counterpart of the one-bit-per-clock `transmit` block. It samples one line bit per `clk` cycle in 8N1-style framing: start bit 0, `bits` data bits LSB first, then one stop bit 1. Completed bytes are buffered in a small FIFO and presented on a valid/ready output. The block sits on the serial line opposite a `transmit` instance, either across a link or in loopback.

## Interface
- `bits`, default 8: data bits per frame; sets the `out` width.
- `depth`, default 4: FIFO entries; must be a power of two, ≥2.
- `clk` input, 1: single clock. Every register is on its rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `en` input, 1: arms start-bit detection. Low blocks new frames; a frame already in progress always completes.
- `in` input, 1: serial line. Idles high.
- `out` output, `bits`: FIFO head byte. Reads 0 whenever `valid`=0.
- `valid` output, 1: FIFO not empty.
- `ready` input, 1: consumer accepts `out`. A pop occurs on `valid & ready`.
- `busy` output, 1: a frame is being received (states DATA and STOP).
- `frameErr` output, 1: one-cycle pulse when the stop bit samples 0.
- `overrun` output, 1: one-cycle pulse when a good frame is dropped because the FIFO is full.

## Operation
- FSM states: WAITHIGH, IDLE, DATA, STOP. Reset state is WAITHIGH.
- WAITHIGH: stay until the sampled line `s` = 1, then go to IDLE. This prevents a false start after reset or after a framing error.
- IDLE: on `en & (s==0)` go to DATA, clear `bitIndex`, set `busy`=1.
- DATA: shift `s` into the shift register LSB first, one bit per cycle. When `bitIndex == bits-1`, go to STOP; otherwise increment `bitIndex`. `bitIndex` width is `$clog2(bits)`.
- STOP, `s`=1: push the byte. Go to IDLE, `busy`=0.
- STOP, `s`=0: pulse `frameErr`, discard the byte, go to WAITHIGH, `busy`=0.
- Back-to-back frames with zero idle cycles are supported: IDLE can detect a start bit on the cycle after STOP.
- FIFO full and a push with no pop in the same cycle: drop the byte, pulse `overrun`. FIFO contents are unchanged.
- FIFO full with a push and a pop in the same cycle: both succeed, and the count is unchanged.
- Empty FIFO with a push: `valid` rises the next cycle. The pushed byte does not bypass to `out` in the same cycle.
- FIFO pointers wrap modulo `depth`. The count is `$clog2(depth)+1` bits wide.
- Reset values: `out`=0, `valid`=0, `busy`=0, `frameErr`=0, `overrun`=0. FIFO is emptied, shift register cleared, FSM goes to WAITHIGH.
- Reset asserted mid-frame: the partial byte is lost and no flag pulses.

## Timing
- Let cycle S be the edge that samples the stop bit. `valid`, `frameErr` or `overrun` assert after edge S.
- Loopback from `transmit` (no sync): the start bit appears on `in` one cycle after `transmit` enters startBit. The byte is valid `bits`+2 cycles after `in` first goes low.
- `busy` is high from the edge after start detection through edge S, i.e. `bits`+1 cycles.
- With RX_SYNC_EN, every sample is taken 2 cycles later. All latencies grow by 2; throughput is unchanged.
- Throughput: one byte per `bits`+2 cycles at maximum.

## Configuration
- `UART_RX_SYNC_EN` defined: `in` passes through a two-flop synchronizer before `s`. Both flops reset to 1. Use this for an asynchronous line.
- `UART_RX_SYNC_EN` undefined: `s` = `in` directly. Use this for same-clock links such as `transmit` loopback.

## Structure
- Shared package `uart_pkg`:
  - State encoding enum, 2 bits.
  - Defaults `UART_BITS`=8 and `UART_RX_DEPTH`=4.
  - Both `uart_receive` and a future refactor of `transmit` use this package.
- Sub-module `uart_rx_fifo`:
  - Synchronous FIFO with `push`/`pop`/`full`/`empty`, parameterized by width and `depth`.
  - `uart_receive` instantiates it once.
  - Overrun detection stays in the parent.

## Test plan
- Loopback with `transmit`, `in`=8'hA5, `ready`=1 → one `valid` pulse with `out`=8'hA5. `frameErr`=0, `overrun`=0.
- Drive frames 8'h01, 8'h80, 8'hFF with zero gap and `ready`=0 → FIFO holds 3 entries. Popping returns them in that order.
- 5 frames 8'h10–8'h14 with `ready`=0 and `depth`=4 → one `overrun` pulse on the 5th frame. Pops return 8'h10–8'h13.
- Frame 8'h3C with stop bit forced to 0 → one `frameErr` pulse and no push. Holding the line low 3 more cycles starts no frame. The next good frame 8'h3C is received.
- Assert `rst` at data bit 4 of a frame, with `in` still low → outputs reset to 0. No false byte is received. The next full frame decodes correctly.
- With `en`=0 during a start bit → no reception and `busy` stays 0. Dropping `en` mid-frame → the frame still completes.
